// File: rtl/mac_test_pkg.sv
// mac_test_pkg: shared status bit indices, checker state encoding and LFSR taps for the MAC test blocks
package mac_test_pkg;
  localparam int ST_PAT = 0;
  localparam int ST_LEN = 1;
  localparam int ST_USER = 2;
  localparam int ST_OVR = 3;
  typedef enum logic [1:0] {IDLE, RECV, DROP} chk_state_t;
  // x^8+x^6+x^5+x^4+1 as feedback taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/axis_frame_checker_if.sv
// axis_frame_checker_if: byte-wide AXI-stream bundle
// ready (sink->source), valid/bits_tdata/bits_tlast/bits_tuser (source->sink)
interface axis_frame_checker_if;
  logic       ready;
  logic       valid;
  logic [7:0] bits_tdata;
  logic       bits_tlast;
  logic       bits_tuser;
  modport master(input ready, output valid, bits_tdata, bits_tlast, bits_tuser);
  modport slave(output ready, input valid, bits_tdata, bits_tlast, bits_tuser);
endinterface

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR that advances while enabled and reloads its seed on reset
// clock/reset: sync active-high; i_enable: advance; i_seed: reset value (non-zero); o_state: register contents
module lfsr8
  import mac_test_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [7:0] i_seed,
  output logic [7:0] o_state
);
  logic [7:0] r_state;
  always_ff @(posedge clock) begin
    if (reset) r_state <= i_seed;
    else if (i_enable) r_state <= {r_state[6:0], ^(r_state & LFSR_TAPS)};
  end
  assign o_state = r_state;
endmodule

// File: rtl/axis_frame_checker.sv
// axis_frame_checker: AXI-stream sink checking frames against the incrementing-byte pattern with saturating stats
// clock/reset: sync active-high; io_axis: slave stream; io_stall_en: LFSR backpressure enable
// io_frame_done: completion pulse; io_status: {ovr,user,len,pat}; io_last_len/io_frame_cnt/io_err_cnt: saturating stats
// io_busy: frame in progress
module axis_frame_checker
  import mac_test_pkg::*;
#(
  parameter int         EXP_LEN   = 64,
  parameter int         MAX_LEN   = 1518,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                        clock,
  input  logic                        reset,
  axis_frame_checker_if.slave         io_axis,
  input  logic                        io_stall_en,
  output logic                        io_frame_done,
  output logic [3:0]                  io_status,
  output logic [15:0]                 io_last_len,
  output logic [15:0]                 io_frame_cnt,
  output logic [15:0]                 io_err_cnt,
  output logic                        io_busy
);
  localparam logic [16:0] MAX_LIM = 17'(MAX_LEN);
  localparam logic [15:0] EXP_L = 16'(EXP_LEN);
  chk_state_t  r_state, w_next;
  logic [7:0]  w_lfsr;
  logic        w_unused;
  logic [15:0] r_idx, r_last_len, r_frame_cnt, r_err_cnt, w_len;
  logic [3:0]  r_status, w_flags;
  logic        r_pat, r_ovr, r_done, w_acc, w_first, w_hit, w_pat, w_ovr;
  lfsr8 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_enable(io_stall_en),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );
  // ready depends only on registered state, never on valid
  assign io_axis.ready = ~io_stall_en | w_lfsr[0];
  assign w_unused = ^w_lfsr[7:1];
  always_comb begin
    w_acc = io_axis.valid & io_axis.ready;
    w_first = r_state == IDLE;
    // w_len is the frame length including the current beat; r_idx is the index of the current beat
    w_len = w_first ? 16'd1 : r_idx + {15'd0, ~&r_idx};
    w_hit = r_state == RECV && {1'b0, w_len} > MAX_LIM;
    w_pat = (~w_first & r_pat) | (r_state != DROP && io_axis.bits_tdata != (w_first ? 8'd0 : r_idx[7:0]));
    w_ovr = (~w_first & r_ovr) | w_hit;
    w_flags = '0;
    w_flags[ST_PAT] = w_pat;
    w_flags[ST_LEN] = w_len != EXP_L;
    w_flags[ST_USER] = io_axis.bits_tuser;
    w_flags[ST_OVR] = w_ovr;
    w_next = !w_acc ? r_state : io_axis.bits_tlast ? IDLE : w_first ? RECV : w_hit ? DROP : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= '0;
      r_pat <= 1'b0;
      r_ovr <= 1'b0;
      r_done <= 1'b0;
      r_status <= '0;
      r_last_len <= '0;
      r_frame_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_done <= w_acc & io_axis.bits_tlast;
      if (w_acc) begin
        r_idx <= w_len;
        r_pat <= w_pat;
        r_ovr <= w_ovr;
      end
      if (w_acc & io_axis.bits_tlast) begin
        r_status <= w_flags;
        r_last_len <= w_len;
        r_frame_cnt <= r_frame_cnt + {15'd0, ~&r_frame_cnt};
        if (|w_flags) r_err_cnt <= r_err_cnt + {15'd0, ~&r_err_cnt};
      end
    end
  end
  assign io_frame_done = r_done;
  assign io_status = r_status;
  assign io_last_len = r_last_len;
  assign io_frame_cnt = r_frame_cnt;
  assign io_err_cnt = r_err_cnt;
  assign io_busy = r_state != IDLE;
endmodule

// File: tb/tb_axis_frame_checker.sv
// tb_axis_frame_checker: directed self-checking bench for axis_frame_checker
module tb_axis_frame_checker;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_stall_en = 1'b0;
  logic        io_frame_done, io_busy;
  logic [3:0]  io_status;
  logic [15:0] io_last_len, io_frame_cnt, io_err_cnt;
  logic [7:0]  m;
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  axis_frame_checker_if io_axis();
  axis_frame_checker dut (
    .clock        (clock),
    .reset        (reset),
    .io_axis      (io_axis),
    .io_stall_en  (io_stall_en),
    .io_frame_done(io_frame_done),
    .io_status    (io_status),
    .io_last_len  (io_last_len),
    .io_frame_cnt (io_frame_cnt),
    .io_err_cnt   (io_err_cnt),
    .io_busy      (io_busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (reset) m <= 8'hA5;
    else if (io_stall_en) m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end
  always @(negedge clock) if (io_frame_done === 1'b1) done_seen++;
  task automatic send(input logic [7:0] d, input logic l, input logic u);
    int n;
    io_axis.valid = 1'b1;
    io_axis.bits_tdata = d;
    io_axis.bits_tlast = l;
    io_axis.bits_tuser = u;
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (io_axis.ready === 1'b1) break;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready low for %0d cycles, required acceptance", n);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic send_frame(input int len, input int bad, input logic [7:0] bad_val, input logic user_last, input int user_mid);
    for (int i = 0; i < len; i++)
      send((i == bad) ? bad_val : 8'(i), i == len - 1, (i == len - 1) ? user_last : (i == user_mid));
    io_axis.valid = 1'b0;
    io_axis.bits_tlast = 1'b0;
    io_axis.bits_tuser = 1'b0;
  endtask
  task automatic test_reset;
    io_axis.valid = 1'b0;
    io_axis.bits_tdata = 8'd0;
    io_axis.bits_tlast = 1'b0;
    io_axis.bits_tuser = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (io_status !== 4'd0) begin errors++; $display("FAIL rst_status: got %b want 0000", io_status); end
    checks++; if (io_last_len !== 16'd0) begin errors++; $display("FAIL rst_last_len: got %0d want 0", io_last_len); end
    checks++; if (io_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", io_err_cnt); end
    checks++; if (io_frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", io_frame_done); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", io_busy); end
    checks++; if (io_axis.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", io_axis.ready); end
  endtask
  task automatic test_good_frame;
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        io_axis.valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (io_busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", io_busy); end
      end
      send(8'(i), i == 63, 1'b0);
    end
    io_axis.valid = 1'b0;
    io_axis.bits_tlast = 1'b0;
    checks++; if (io_frame_done !== 1'b1) begin errors++; $display("FAIL good_done: got %b want 1", io_frame_done); end
    checks++; if (io_status !== 4'b0000) begin errors++; $display("FAIL good_status: got %b want 0000", io_status); end
    checks++; if (io_last_len !== 16'd64) begin errors++; $display("FAIL good_len: got %0d want 64", io_last_len); end
    checks++; if (io_frame_cnt !== 16'd1) begin errors++; $display("FAIL good_cnt: got %0d want 1", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd0) begin errors++; $display("FAIL good_err: got %0d want 0", io_err_cnt); end
    @(posedge clock);
    #1;
    checks++; if (io_frame_done !== 1'b0) begin errors++; $display("FAIL good_done_pulse: got %b want 0", io_frame_done); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b want 0", io_busy); end
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL good_pulses: got %0d want 1", done_seen - d0); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) send((i == 10) ? 8'hFF : 8'(i), i == 63, 1'b0);
    checks++; if (io_status !== 4'b0001) begin errors++; $display("FAIL b2b_status1: got %b want 0001", io_status); end
    checks++; if (io_frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt1: got %0d want 2", io_frame_cnt); end
    send_frame(63, -1, 8'h00, 1'b0, -1);
    checks++; if (io_status !== 4'b0010) begin errors++; $display("FAIL b2b_status2: got %b want 0010", io_status); end
    checks++; if (io_last_len !== 16'd63) begin errors++; $display("FAIL b2b_len2: got %0d want 63", io_last_len); end
    checks++; if (io_frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt2: got %0d want 3", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd2) begin errors++; $display("FAIL b2b_err: got %0d want 2", io_err_cnt); end
  endtask
  task automatic test_tuser;
    send_frame(64, -1, 8'h00, 1'b1, 5);
    checks++; if (io_status !== 4'b0100) begin errors++; $display("FAIL tuser_status: got %b want 0100", io_status); end
    checks++; if (io_err_cnt !== 16'd3) begin errors++; $display("FAIL tuser_err: got %0d want 3", io_err_cnt); end
    send_frame(64, -1, 8'h00, 1'b0, 5);
    checks++; if (io_status !== 4'b0000) begin errors++; $display("FAIL tuser_mid_status: got %b want 0000", io_status); end
    checks++; if (io_frame_cnt !== 16'd5) begin errors++; $display("FAIL tuser_cnt: got %0d want 5", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd3) begin errors++; $display("FAIL tuser_mid_err: got %0d want 3", io_err_cnt); end
  endtask
  task automatic test_one_byte;
    send_frame(1, -1, 8'h00, 1'b0, -1);
    checks++; if (io_status !== 4'b0010) begin errors++; $display("FAIL one_status: got %b want 0010", io_status); end
    checks++; if (io_last_len !== 16'd1) begin errors++; $display("FAIL one_len: got %0d want 1", io_last_len); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL one_busy: got %b want 0", io_busy); end
    checks++; if (io_frame_cnt !== 16'd6) begin errors++; $display("FAIL one_cnt: got %0d want 6", io_frame_cnt); end
  endtask
  task automatic test_oversize;
    send_frame(1518, -1, 8'h00, 1'b0, -1);
    checks++; if (io_status !== 4'b0010) begin errors++; $display("FAIL max_status: got %b want 0010", io_status); end
    checks++; if (io_last_len !== 16'd1518) begin errors++; $display("FAIL max_len: got %0d want 1518", io_last_len); end
    send_frame(1519, -1, 8'h00, 1'b0, -1);
    checks++; if (io_status !== 4'b1010) begin errors++; $display("FAIL max1_status: got %b want 1010", io_status); end
    checks++; if (io_last_len !== 16'd1519) begin errors++; $display("FAIL max1_len: got %0d want 1519", io_last_len); end
    send_frame(1600, 1550, 8'hFF, 1'b0, -1);
    checks++; if (io_status !== 4'b1010) begin errors++; $display("FAIL drop_status: got %b want 1010", io_status); end
    checks++; if (io_last_len !== 16'd1600) begin errors++; $display("FAIL drop_len: got %0d want 1600", io_last_len); end
    checks++; if (io_frame_cnt !== 16'd9) begin errors++; $display("FAIL drop_cnt: got %0d want 9", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd7) begin errors++; $display("FAIL drop_err: got %0d want 7", io_err_cnt); end
  endtask
  task automatic test_stall;
    int d0, zeros;
    zeros = 0;
    io_stall_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      checks++; if (io_axis.ready !== m[0]) begin errors++; $display("FAIL stall_ready[%0d]: got %b want %b", c, io_axis.ready, m[0]); end
      if (io_axis.ready === 1'b0) zeros++;
    end
    checks++; if (zeros == 0) begin errors++; $display("FAIL stall_toggles: got %0d low cycles want >0", zeros); end
    @(posedge clock);
    #1;
    d0 = done_seen;
    for (int f = 0; f < 20; f++) send_frame(64, -1, 8'h00, 1'b0, -1);
    @(posedge clock);
    #1;
    io_stall_en = 1'b0;
    checks++; if (io_frame_cnt !== 16'd29) begin errors++; $display("FAIL stall_cnt: got %0d want 29", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd7) begin errors++; $display("FAIL stall_err: got %0d want 7", io_err_cnt); end
    checks++; if (io_status !== 4'b0000) begin errors++; $display("FAIL stall_status: got %b want 0000", io_status); end
    checks++; if (done_seen - d0 !== 20) begin errors++; $display("FAIL stall_pulses: got %0d want 20", done_seen - d0); end
    checks++; if (io_axis.ready !== 1'b1) begin errors++; $display("FAIL stall_off_ready: got %b want 1", io_axis.ready); end
  endtask
  task automatic test_reset_midframe;
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 30; i++) send(8'(i), 1'b0, 1'b0);
    checks++; if (io_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", io_busy); end
    io_axis.valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", io_busy); end
    checks++; if (io_frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", io_frame_cnt); end
    checks++; if (io_err_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_err: got %0d want 0", io_err_cnt); end
    checks++; if (io_last_len !== 16'd0) begin errors++; $display("FAIL mid_rst_len: got %0d want 0", io_last_len); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL mid_rst_pulses: got %0d want 0", done_seen - d0); end
    send_frame(64, -1, 8'h00, 1'b0, -1);
    checks++; if (io_frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_good_cnt: got %0d want 1", io_frame_cnt); end
    checks++; if (io_status !== 4'b0000) begin errors++; $display("FAIL mid_good_status: got %b want 0000", io_status); end
    checks++; if (io_err_cnt !== 16'd0) begin errors++; $display("FAIL mid_good_err: got %0d want 0", io_err_cnt); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_tuser();
    test_one_byte();
    test_oversize();
    test_stall();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
